// File: rtl/link_beat_deframer.sv
// Link beat deframer: rebuilds wide hub messages from MSB-first narrow beats.
// Optional stalled-partial supervision is enabled by LINK_BEAT_TIMEOUT_EN.
module link_beat_deframer #(
    parameter int HUB_FIFO_WIDTH          = 32,
    parameter int HUB_FIFO_PHYSICAL_WIDTH = 8,
    parameter int COUNT_WIDTH             = 16,
    parameter int TIMEOUT_CYCLES          = 64
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [HUB_FIFO_PHYSICAL_WIDTH-1:0] narrow_fifo_data,
    input  logic                               narrow_fifo_valid,
    output logic                               narrow_fifo_ready,
    output logic [HUB_FIFO_WIDTH-1:0]          wide_fifo_data,
    output logic                               wide_fifo_valid,
    input  logic                               wide_fifo_ready,
    output logic                               busy,
    output logic [COUNT_WIDTH-1:0]             words_received,
    output logic                               frame_error
);

    localparam int W     = HUB_FIFO_WIDTH;
    localparam int P     = HUB_FIFO_PHYSICAL_WIDTH;
    localparam int BEATS = W / P;
    localparam int CW    = $clog2(BEATS) + 1;
    localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

    generate
        if (W % P != 0 || BEATS < 1) begin : g_bad_width
            $error("HUB_FIFO_WIDTH must be a multiple of HUB_FIFO_PHYSICAL_WIDTH");
        end
        if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
            $error("TIMEOUT_CYCLES must be at least 1");
        end
    endgenerate

    logic [CW-1:0]          cnt_q, cnt_d;
    logic [W-1:0]           asm_q, asm_d;
    logic [W-1:0]           data_q, data_d;
    logic                   valid_q, valid_d;
    logic [COUNT_WIDTH-1:0] words_q, words_d;

    logic         last_beat;
    logic         accept;
    logic         wide_hs;
    logic [W-1:0] shifted;

    // MSB-first: earlier beats migrate toward the top of the word
    generate
        if (BEATS == 1) begin : g_single
            assign shifted = narrow_fifo_data;
        end else begin : g_multi
            assign shifted = {asm_q[W-P-1:0], narrow_fifo_data};
        end
    endgenerate

`ifdef LINK_BEAT_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] tmo_q, tmo_d;
    logic          ferr_q, ferr_d;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            asm_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            words_q <= '0;
`ifdef LINK_BEAT_TIMEOUT_EN
            tmo_q   <= '0;
            ferr_q  <= 1'b0;
`endif
        end else begin
            cnt_q   <= cnt_d;
            asm_q   <= asm_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            words_q <= words_d;
`ifdef LINK_BEAT_TIMEOUT_EN
            tmo_q   <= tmo_d;
            ferr_q  <= ferr_d;
`endif
        end
    end

    always_comb begin
        cnt_d   = cnt_q;
        asm_d   = asm_q;
        data_d  = data_q;
        valid_d = valid_q;
        words_d = words_q;
`ifdef LINK_BEAT_TIMEOUT_EN
        tmo_d   = tmo_q;
        ferr_d  = 1'b0;
`endif
        if (wide_hs) begin
            valid_d = 1'b0;
            words_d = words_q + 1'b1;
        end
        if (accept) begin
            asm_d = shifted;
            if (last_beat) begin
                cnt_d   = '0;
                data_d  = shifted;
                valid_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
`ifdef LINK_BEAT_TIMEOUT_EN
        // Backpressured stalls hold the counter; only starved cycles count
        if (accept || cnt_q == '0) begin
            tmo_d = '0;
        end else if (!narrow_fifo_valid) begin
            if (tmo_q == TLIM) begin
                cnt_d  = '0;
                asm_d  = '0;
                ferr_d = 1'b1;
                tmo_d  = '0;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
`endif
    end

    always_comb begin
        last_beat         = (cnt_q == LAST);
        narrow_fifo_ready = !(last_beat && valid_q && !wide_fifo_ready);
        accept            = narrow_fifo_valid && narrow_fifo_ready;
        wide_hs           = valid_q && wide_fifo_ready;
        wide_fifo_data    = data_q;
        wide_fifo_valid   = valid_q;
        words_received    = words_q;
        busy              = (cnt_q != '0) || valid_q;
`ifdef LINK_BEAT_TIMEOUT_EN
        frame_error       = ferr_q;
`else
        frame_error       = 1'b0;
`endif
    end

endmodule
